// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared types and helpers for the gshare branch predictor.
//   - state_t     : predictor FSM (INIT sweeps the PHT, RUN predicts/trains)
//   - SNT..ST     : 2-bit saturating counter encodings
//   - pht_hash    : PHT index hash (history XOR PC bits)
//   - ctr_next    : saturating counter update
// Build option: GSHARE_PC_HASH_EN
//   defined   -> PHT index = history ^ pc[GHR_BITS+1:2]
//   undefined -> PHT index = history only (pure global-history indexing)
// -----------------------------------------------------------------------------
package bp_pkg;

   typedef enum logic {INIT, RUN} state_t;

   localparam logic [1:0] SNT = 2'd0;
   localparam logic [1:0] WNT = 2'd1;
   localparam logic [1:0] WT  = 2'd2;
   localparam logic [1:0] ST  = 2'd3;

   // Widest supported history; the hash works at this width and callers
   // keep the low GHR_BITS bits.
   localparam int HASH_W = 10;

`ifdef GSHARE_PC_HASH_EN
   localparam bit PC_HASH_EN = 1'b1;
`else
   localparam bit PC_HASH_EN = 1'b0;
`endif

   function automatic logic [HASH_W-1:0] pht_hash(input logic [HASH_W-1:0] hist,
                                                  input logic [HASH_W-1:0] pc_bits);
      return hist ^ (PC_HASH_EN ? pc_bits : '0);
   endfunction

   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      if (taken)
         return (ctr == ST) ? ST : ctr + 2'd1;
      else
         return (ctr == SNT) ? SNT : ctr - 2'd1;
   endfunction

endpackage

// File: rtl/bp_btb.sv
// -----------------------------------------------------------------------------
// bp_btb
// Fully-associative branch target buffer with round-robin replacement.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   lk_pc               fetch lookup PC[31:2]
//   lk_hit, lk_target   fetch lookup result (target 0 on miss)
//   ex_pc               resolve-stage PC[31:2]; also the write address
//   ex_hit, ex_cur      current entry for ex_pc (target 0 on miss)
//   wr_en, wr_target    write ex_pc -> wr_target (overwrite on hit, else
//                       allocate at the round-robin pointer)
// -----------------------------------------------------------------------------
module bp_btb #(
   parameter int ENTRIES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [29:0] lk_pc,
   output logic        lk_hit,
   output logic [31:0] lk_target,
   input  logic [29:0] ex_pc,
   output logic        ex_hit,
   output logic [31:0] ex_cur,
   input  logic        wr_en,
   input  logic [31:0] wr_target
);

   localparam int PW = $clog2(ENTRIES);

   logic [ENTRIES-1:0] valid;
   logic [29:0]        tag    [ENTRIES];
   logic [31:0]        target [ENTRIES];
   logic [PW-1:0]      ptr;
   logic [PW-1:0]      ex_idx;
   logic [PW-1:0]      wr_idx;

   // Tags are unique (a hitting write overwrites in place), so at most one
   // entry matches and the loop needs no priority.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      lk_hit    = 1'b0;
      lk_target = '0;
      ex_hit    = 1'b0;
      ex_cur    = '0;
      ex_idx    = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (valid[i] && tag[i] == lk_pc) begin
            lk_hit    = 1'b1;
            lk_target = target[i];
         end
         if (valid[i] && tag[i] == ex_pc) begin
            ex_hit = 1'b1;
            ex_cur = target[i];
            ex_idx = PW'(i);
         end
      end
   end

   assign wr_idx = ex_hit ? ex_idx : ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         // NOTE: state registers use <= so every flop samples pre-edge values.
         valid <= '0;
         ptr   <= '0;
      end else if (wr_en) begin
         valid[wr_idx] <= 1'b1;
         if (!ex_hit)
            ptr <= ptr + 1'b1;
      end
   end

   // NOTE: tag/target arrays are storage qualified by valid, so they carry no reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         tag[wr_idx]    <= ex_pc;
         target[wr_idx] <= wr_target;
      end
   end

endmodule

// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
// Global-history branch predictor: BTB (bp_btb) + speculative GHR with
// mispredict recovery + PHT of 2-bit saturating counters.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    re-initialise the PHT (restart sweep)
//   if_valid, if_pc          fetch lookup (same-cycle answer)
//   pred_taken, pred_target  prediction (target 0 on BTB miss)
//   pred_ghr                 GHR snapshot to carry down the pipe
//   ex_valid, ex_is_branch, ex_pc, ex_taken, ex_target,
//   ex_pred_taken, ex_ghr    resolved branch from execute
//   mispredict, redirect_pc  combinational redirect
//   ready                    PHT sweep complete
// Build option: GSHARE_PC_HASH_EN selects history^PC indexing of the PHT;
// when undefined the PHT is indexed by history alone.
// -----------------------------------------------------------------------------
module gshare_predictor
   import bp_pkg::*;
#(
   parameter int BTB_ENTRIES = 8,
   parameter int GHR_BITS    = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                if_valid,
   input  logic [31:0]         if_pc,
   output logic                pred_taken,
   output logic [31:0]         pred_target,
   output logic [GHR_BITS-1:0] pred_ghr,
   input  logic                ex_valid,
   input  logic                ex_is_branch,
   input  logic [31:0]         ex_pc,
   input  logic                ex_taken,
   input  logic [31:0]         ex_target,
   input  logic                ex_pred_taken,
   input  logic [GHR_BITS-1:0] ex_ghr,
   output logic                mispredict,
   output logic [31:0]         redirect_pc,
   output logic                ready
);

   localparam int PHT_SIZE = 1 << GHR_BITS;

   state_t              state;
   logic [GHR_BITS-1:0] sweep;
   logic [GHR_BITS-1:0] ghr;
   logic [1:0]          pht [PHT_SIZE];

   logic                lk_hit;
   logic [31:0]         lk_target;
   logic                ex_hit;
   logic [31:0]         ex_cur;
   logic                ex_res;
   logic [HASH_W-1:0]   if_hash;
   logic [HASH_W-1:0]   ex_hash;
   logic [GHR_BITS-1:0] if_idx;
   logic [GHR_BITS-1:0] ex_idx;
   logic                unused_bits;

   bp_btb #(.ENTRIES(BTB_ENTRIES)) u_btb (
      .clk       (clk),
      .rst       (rst),
      .lk_pc     (if_pc[31:2]),
      .lk_hit    (lk_hit),
      .lk_target (lk_target),
      .ex_pc     (ex_pc[31:2]),
      .ex_hit    (ex_hit),
      .ex_cur    (ex_cur),
      .wr_en     (ex_res & ex_taken),
      .wr_target (ex_target)
   );

   assign if_hash = pht_hash(HASH_W'(ghr),    HASH_W'(if_pc[GHR_BITS+1:2]));
   assign ex_hash = pht_hash(HASH_W'(ex_ghr), HASH_W'(ex_pc[GHR_BITS+1:2]));
   assign if_idx  = if_hash[GHR_BITS-1:0];
   assign ex_idx  = ex_hash[GHR_BITS-1:0];
   assign unused_bits = ^{if_pc[1:0], if_hash, ex_hash};

   assign ready       = (state == RUN);
   assign pred_taken  = lk_hit & pht[if_idx][1] & ready;
   assign pred_target = lk_target;
   assign pred_ghr    = ghr;

   // The fetch-time target is not carried, so a taken/taken resolve is
   // checked against whatever the BTB holds for ex_pc now (0 on miss).
   assign ex_res      = ex_valid & ex_is_branch;
   assign mispredict  = ex_res & ((ex_taken != ex_pred_taken) |
                                  (ex_taken & ex_pred_taken & (ex_target != ex_cur)));
   assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

   // FSM and sweep counter; flush from either state restarts at index 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= INIT;
         sweep <= '0;
      end else if (flush) begin
         state <= INIT;
         sweep <= '0;
      end else if (state == INIT) begin
         if (sweep == '1)
            state <= RUN;
         sweep <= sweep + 1'b1;
      end
   end

   // Recovery wins over the speculative shift of a same-cycle lookup.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ghr <= '0;
      else if (mispredict)
         ghr <= {ex_ghr[GHR_BITS-2:0], ex_taken};
      else if (if_valid & lk_hit)
         ghr <= {ghr[GHR_BITS-2:0], pred_taken};
   end

   // Training is dropped during the sweep and on a flush edge.
   always_ff @(posedge clk) begin
      if (state == INIT)
         pht[sweep] <= WNT;
      else if (ex_res & ~flush)
         pht[ex_idx] <= ctr_next(pht[ex_idx], ex_taken);
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// -----------------------------------------------------------------------------
// tb_gshare_predictor
// Directed bench for gshare_predictor (BTB_ENTRIES=8, GHR_BITS=4, default
// build: PHT indexed by history only). Inputs change on the falling edge and
// outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_gshare_predictor;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        if_valid;
   logic [31:0] if_pc;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic [3:0]  pred_ghr;
   logic        ex_valid;
   logic        ex_is_branch;
   logic [31:0] ex_pc;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ex_pred_taken;
   logic [3:0]  ex_ghr;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic        ready;

   int n_checks = 0;
   int n_fail   = 0;
   int cycles;

   gshare_predictor #(.BTB_ENTRIES(8), .GHR_BITS(4)) dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .pred_taken    (pred_taken),
      .pred_target   (pred_target),
      .pred_ghr      (pred_ghr),
      .ex_valid      (ex_valid),
      .ex_is_branch  (ex_is_branch),
      .ex_pc         (ex_pc),
      .ex_taken      (ex_taken),
      .ex_target     (ex_target),
      .ex_pred_taken (ex_pred_taken),
      .ex_ghr        (ex_ghr),
      .mispredict    (mispredict),
      .redirect_pc   (redirect_pc),
      .ready         (ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_ex();
      ex_valid      = 1'b0;
      ex_is_branch  = 1'b0;
      ex_pc         = '0;
      ex_taken      = 1'b0;
      ex_target     = '0;
      ex_pred_taken = 1'b0;
      ex_ghr        = '0;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                          input logic pred, input logic [3:0] g);
      ex_valid      = 1'b1;
      ex_is_branch  = 1'b1;
      ex_pc         = pc;
      ex_taken      = taken;
      ex_target     = tgt;
      ex_pred_taken = pred;
      ex_ghr        = g;
   endtask

   task automatic lookup(input logic [31:0] pc);
      if_valid = 1'b1;
      if_pc    = pc;
   endtask

   initial begin
      rst = 1'b1;
      flush = 1'b0;
      if_valid = 1'b0;
      if_pc = '0;
      clear_ex();

      // Reset values with idle inputs.
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready",       32'(ready),       32'd0);
      check("rst_pred_taken",  32'(pred_taken),  32'd0);
      check("rst_pred_target", pred_target,      32'd0);
      check("rst_pred_ghr",    32'(pred_ghr),    32'd0);
      check("rst_mispredict",  32'(mispredict),  32'd0);

      // Sweep cycle 0: taken resolve, predicted not-taken -> BTB alloc, GHR=0001.
      @(negedge clk);
      rst = 1'b0;
      resolve(32'h100, 1'b1, 32'h200, 1'b0, 4'h0);
      #1;
      check("init_mispredict", 32'(mispredict), 32'd1);
      check("init_redirect",   redirect_pc,     32'h200);
      check("init_ready",      32'(ready),      32'd0);

      // Sweep cycle 1: BTB hit but pred_taken held low.
      @(negedge clk);
      clear_ex();
      lookup(32'h100);
      #1;
      check("init_hit_target", pred_target,    32'h200);
      check("init_hit_taken",  32'(pred_taken), 32'd0);
      check("init_ghr",        32'(pred_ghr),   32'h1);

      // Lookup shifts in 0 -> GHR=0010. Count cycles until ready.
      @(negedge clk);
      if_valid = 1'b0;
      #1;
      cycles = 2;
      while (!ready && cycles < 40) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      check("init_length", 32'(cycles), 32'd16);

      // Train counter[2] (ex_ghr=0010) taken 3 times: 1->2->3->3.
      for (int i = 0; i < 3; i++) begin
         resolve(32'h100, 1'b1, 32'h200, 1'b1, 4'b0010);
         #1;
         check("train_no_mispredict", 32'(mispredict), 32'd0);
         @(negedge clk);
      end
      clear_ex();
      lookup(32'h100);
      #1;
      check("trained_taken",  32'(pred_taken), 32'd1);
      check("trained_target", pred_target,     32'h200);
      check("trained_ghr",    32'(pred_ghr),   32'b0010);

      // Predicted taken, actually not taken.
      @(negedge clk);
      if_valid = 1'b0;
      resolve(32'h100, 1'b0, 32'h200, 1'b1, 4'b0010);
      #1;
      check("nt_mispredict", 32'(mispredict), 32'd1);
      check("nt_redirect",   redirect_pc,     32'h104);

      // Restored GHR {010,0}; same cycle: hitting lookup plus mispredict.
      @(negedge clk);
      resolve(32'h100, 1'b1, 32'h200, 1'b0, 4'b1001);
      lookup(32'h100);
      #1;
      check("recover_ghr",      32'(pred_ghr),   32'b0100);
      check("both_mispredict",  32'(mispredict), 32'd1);
      check("both_pred_taken",  32'(pred_taken), 32'd0);

      // Recovery {001,1} wins over speculative {100,0}.
      @(negedge clk);
      if_valid = 1'b0;
      clear_ex();
      #1;
      check("priority_ghr", 32'(pred_ghr), 32'b0011);

      // Nine distinct taken branches; the 9th allocation evicts 0x1000.
      for (int i = 0; i < 9; i++) begin
         resolve(32'h1000 + 32'(4 * i), 1'b1, 32'h2000 + 32'(4 * i), 1'b0, 4'h0);
         @(negedge clk);
      end
      clear_ex();
      lookup(32'h1000);
      #1;
      check("evict_target", pred_target,     32'h0);
      check("evict_taken",  32'(pred_taken), 32'd0);

      @(negedge clk);
      lookup(32'h1020);
      #1;
      check("newest_target", pred_target,   32'h2020);
      check("newest_ghr",    32'(pred_ghr), 32'b0001);

      // Force GHR to 0; counter[0] drops 3->2 (still taken).
      @(negedge clk);
      if_valid = 1'b0;
      resolve(32'h1020, 1'b0, 32'h2020, 1'b1, 4'h0);
      #1;
      check("set_mispredict", 32'(mispredict), 32'd1);
      check("set_redirect",   redirect_pc,     32'h1024);

      @(negedge clk);
      clear_ex();
      lookup(32'h1020);
      #1;
      check("preflush_taken", 32'(pred_taken), 32'd1);
      check("preflush_ghr",   32'(pred_ghr),   32'h0);

      // Flush in RUN: GHR is 0001 from here on (no further lookups).
      @(negedge clk);
      if_valid = 1'b0;
      flush = 1'b1;
      #1;
      check("preflush_ready", 32'(ready), 32'd1);

      @(negedge clk);
      flush = 1'b0;
      #1;
      check("flush_ready_low", 32'(ready), 32'd0);
      cycles = 0;
      while (!ready && cycles < 40) begin
         @(negedge clk);
         #1;
         cycles++;
      end
      check("flush_length", 32'(cycles), 32'd16);

      // Counters back to WNT; BTB contents survive the flush.
      lookup(32'h1020);
      #1;
      check("postflush_taken1", 32'(pred_taken), 32'd0);
      check("postflush_target", pred_target,     32'h2020);
      check("postflush_ghr1",   32'(pred_ghr),   32'b0001);

      @(negedge clk);
      #1;
      check("postflush_taken2", 32'(pred_taken), 32'd0);
      check("postflush_ghr2",   32'(pred_ghr),   32'b0010);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
